// File: rtl/flexbex_ibex_irq_ctrl_multi_if.sv
// Request/ack/kill/claim handshake between the interrupt controller and the core controller.
interface flexbex_ibex_irq_ctrl_multi_if #(
  parameter int ID_W = 5
);
  logic            irq_req_ctrl;
  logic [ID_W-1:0] irq_id_ctrl;
  logic            irq_claim;
  logic            ctrl_ack;
  logic            ctrl_kill;

  modport master (output irq_req_ctrl, irq_id_ctrl, irq_claim, input ctrl_ack, ctrl_kill);
  modport slave  (input irq_req_ctrl, irq_id_ctrl, irq_claim, output ctrl_ack, ctrl_kill);
endinterface

// File: rtl/flexbex_ibex_irq_ctrl_multi.sv
// Multi-source interrupt controller: per-source mask and edge/level mode,
// lowest-index priority, req/ack/kill handshake with a one-cycle claim pulse.
module flexbex_ibex_irq_ctrl_multi_src #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  input  logic en,
  input  logic clr,
  output logic elig,
  output logic pend
);
  logic irq_q, pending_q;

  // A rise in the same cycle as the claim clear keeps the source pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      irq_q     <= irq;
      pending_q <= EDGE ? ((pending_q & ~clr) | (irq & ~irq_q)) : 1'b0;
    end
  end

  assign pend = EDGE ? pending_q : irq;
  assign elig = pend & en;
endmodule

module flexbex_ibex_irq_ctrl_multi #(
  parameter int                 NUM_IRQ   = 8,
  parameter int                 ID_W      = 5,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_IRQ-1:0]    irq_i,
  input  logic [NUM_IRQ-1:0]    irq_en_i,
  input  logic                  m_IE_i,
  flexbex_ibex_irq_ctrl_multi_if.master ctrl,
  output logic [NUM_IRQ-1:0]    irq_pending_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, CLAIM = 2'd2} state_e;

  state_e              state_q;
  logic [ID_W-1:0]     id_q, winner;
  logic                req_q, claim_q;
  logic [NUM_IRQ-1:0]  elig, clr;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    assign clr[g] = claim_q && (id_q == ID_W'(g));
    flexbex_ibex_irq_ctrl_multi_src #(.EDGE(EDGE_MASK[g])) u_src (
      .clk  (clk),
      .rst_n(rst_n),
      .irq  (irq_i[g]),
      .en   (irq_en_i[g]),
      .clr  (clr[g]),
      .elig (elig[g]),
      .pend (irq_pending_o[g])
    );
  end

  // Scan downwards so the lowest eligible index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (elig[i]) winner = ID_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      req_q   <= 1'b0;
      claim_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          claim_q <= 1'b0;
          if (m_IE_i && |elig) begin
            state_q <= REQ;
            id_q    <= winner;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (ctrl.ctrl_ack) begin
            state_q <= CLAIM;
            req_q   <= 1'b0;
            claim_q <= 1'b1;
          end else if (ctrl.ctrl_kill) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        CLAIM: begin
          state_q <= IDLE;
          claim_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          claim_q <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl.irq_req_ctrl = req_q;
  assign ctrl.irq_claim    = claim_q;
  assign ctrl.irq_id_ctrl  = id_q;
endmodule

// File: tb/tb_flexbex_ibex_irq_ctrl_multi.sv
// Bench for flexbex_ibex_irq_ctrl_multi: 8 sources, source 3 edge-triggered, rest level.
module tb_flexbex_ibex_irq_ctrl_multi;
  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 5;

  typedef struct packed {
    logic            req;
    logic [ID_W-1:0] id;
    logic            claim;
    logic [7:0]      pend;
  } obs_t;

  typedef struct {
    logic [7:0] irq;
    logic [7:0] en;
    logic       mie;
    logic       ack;
    logic       kill;
    obs_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq, irq_en, irq_pending;
  logic       m_ie;
  int         n_cmp = 0;
  int         n_bad = 0;
  obs_t       sb[$];
  vec_t       tbl[$];

  flexbex_ibex_irq_ctrl_multi_if #(.ID_W(ID_W)) ifc ();

  flexbex_ibex_irq_ctrl_multi #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W), .EDGE_MASK(8'h08)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_i        (irq),
    .irq_en_i     (irq_en),
    .m_IE_i       (m_ie),
    .ctrl         (ifc.master),
    .irq_pending_o(irq_pending)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic r, input int id, input logic c, input logic [7:0] p);
    obs_t o;
    o.req = r; o.id = ID_W'(id); o.claim = c; o.pend = p;
    return o;
  endfunction

  task automatic add(input logic [7:0] i, input logic [7:0] en, input logic mie, input logic ack,
                     input logic kill, input obs_t e);
    vec_t v;
    v.irq = i; v.en = en; v.mie = mie; v.ack = ack; v.kill = kill; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic drv(input logic [7:0] i, input logic [7:0] en, input logic mie, input logic ack,
                     input logic kill);
    irq = i; irq_en = en; m_ie = mie; ifc.ctrl_ack = ack; ifc.ctrl_kill = kill;
  endtask

  task automatic cmp(input string nm);
    obs_t e, a;
    e = sb.pop_front();
    a.req = ifc.irq_req_ctrl; a.id = ifc.irq_id_ctrl; a.claim = ifc.irq_claim; a.pend = irq_pending;
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got req=%0b id=%0d claim=%0b pend=%h, want req=%0b id=%0d claim=%0b pend=%h",
               nm, a.req, a.id, a.claim, a.pend, e.req, e.id, e.claim, e.pend);
    end
  endtask

  // Expected outputs are queued with the stimulus and retired one edge later.
  task automatic cyc(input obs_t e, input string nm);
    sb.push_back(e);
    @(posedge clk); #1;
    cmp(nm);
  endtask

  initial begin
    rst_n = 1'b0;
    drv(8'h24, 8'hFF, 1'b1, 1'b0, 1'b0);
    #12;
    sb.push_back(mk(0, 0, 0, 8'h24));
    cmp("reset_state");
    irq = 8'h00;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Level priority, ack/claim, re-request, ack-over-kill, masking, m_IE drop in REQ.
    add(8'h24, 8'hFF, 1, 0, 0, mk(1, 2, 0, 8'h24));
    add(8'h24, 8'hFF, 1, 0, 0, mk(1, 2, 0, 8'h24));
    add(8'h24, 8'hFF, 1, 0, 0, mk(1, 2, 0, 8'h24));
    add(8'h24, 8'hFF, 1, 1, 0, mk(0, 2, 1, 8'h24));
    add(8'h24, 8'hFF, 1, 0, 0, mk(0, 2, 0, 8'h24));
    add(8'h24, 8'hFF, 1, 0, 0, mk(1, 2, 0, 8'h24));
    add(8'h24, 8'hFF, 1, 1, 1, mk(0, 2, 1, 8'h24));
    add(8'h20, 8'hFF, 1, 0, 0, mk(0, 2, 0, 8'h20));
    add(8'h20, 8'hFF, 1, 0, 0, mk(1, 5, 0, 8'h20));
    add(8'h20, 8'hFF, 1, 0, 1, mk(0, 5, 0, 8'h20));
    add(8'h00, 8'hFF, 1, 0, 0, mk(0, 5, 0, 8'h00));
    add(8'h01, 8'h00, 1, 1, 0, mk(0, 5, 0, 8'h01));
    add(8'h01, 8'hFF, 0, 0, 1, mk(0, 5, 0, 8'h01));
    add(8'h01, 8'hFF, 1, 0, 0, mk(1, 0, 0, 8'h01));
    add(8'h01, 8'hFF, 0, 0, 0, mk(1, 0, 0, 8'h01));
    add(8'h00, 8'h00, 0, 0, 0, mk(1, 0, 0, 8'h00));
    add(8'h00, 8'h00, 0, 1, 0, mk(0, 0, 1, 8'h00));
    add(8'h00, 8'hFF, 1, 0, 0, mk(0, 0, 0, 8'h00));
    add(8'hF7, 8'hF6, 1, 0, 0, mk(1, 1, 0, 8'hF7));
    add(8'h00, 8'hFF, 1, 0, 1, mk(0, 1, 0, 8'h00));
    add(8'h00, 8'hFF, 1, 0, 0, mk(0, 1, 0, 8'h00));
    foreach (tbl[k]) begin
      drv(tbl[k].irq, tbl[k].en, tbl[k].mie, tbl[k].ack, tbl[k].kill);
      cyc(tbl[k].e, $sformatf("vec%0d", k));
    end

    // Ten masked cycles, then enabling raises req one cycle later.
    for (int k = 0; k < 10; k++) begin
      if (k < 5) drv(8'h01, 8'h00, 1, 0, 0);
      else       drv(8'h01, 8'hFF, 0, 0, 0);
      cyc(mk(0, 1, 0, 8'h01), $sformatf("mask%0d", k));
    end
    drv(8'h01, 8'hFF, 1, 0, 0); cyc(mk(1, 0, 0, 8'h01), "mask_enable");
    drv(8'h00, 8'hFF, 1, 0, 1); cyc(mk(0, 0, 0, 8'h00), "mask_kill");

    // Edge pulse latched, acked, pending cleared, no further request.
    drv(8'h08, 8'hFF, 1, 0, 0); cyc(mk(0, 0, 0, 8'h08), "e1_latch");
    drv(8'h00, 8'hFF, 1, 0, 0); cyc(mk(1, 3, 0, 8'h08), "e1_req");
    cyc(mk(1, 3, 0, 8'h08), "e1_hold");
    cyc(mk(1, 3, 0, 8'h08), "e1_hold2");
    drv(8'h00, 8'hFF, 1, 1, 0); cyc(mk(0, 3, 1, 8'h08), "e1_claim");
    drv(8'h00, 8'hFF, 1, 0, 0); cyc(mk(0, 3, 0, 8'h00), "e1_cleared");
    cyc(mk(0, 3, 0, 8'h00), "e1_quiet");
    cyc(mk(0, 3, 0, 8'h00), "e1_quiet2");

    // Kill keeps the edge pending; a rise during CLAIM survives the clear.
    drv(8'h08, 8'hFF, 1, 0, 0); cyc(mk(0, 3, 0, 8'h08), "e2_latch");
    drv(8'h00, 8'hFF, 1, 0, 0); cyc(mk(1, 3, 0, 8'h08), "e2_req");
    cyc(mk(1, 3, 0, 8'h08), "e2_hold");
    cyc(mk(1, 3, 0, 8'h08), "e2_hold2");
    drv(8'h00, 8'hFF, 1, 0, 1); cyc(mk(0, 3, 0, 8'h08), "e2_kill");
    drv(8'h00, 8'hFF, 1, 0, 0); cyc(mk(1, 3, 0, 8'h08), "e2_rereq");
    drv(8'h00, 8'hFF, 1, 1, 0); cyc(mk(0, 3, 1, 8'h08), "e2_claim");
    drv(8'h08, 8'hFF, 1, 0, 0); cyc(mk(0, 3, 0, 8'h08), "e2_rise_in_claim");
    drv(8'h00, 8'hFF, 1, 0, 0); cyc(mk(1, 3, 0, 8'h08), "e2_new_req");
    drv(8'h00, 8'hFF, 1, 1, 1); cyc(mk(0, 3, 1, 8'h08), "e2_ack_kill");
    drv(8'h00, 8'hFF, 1, 0, 0); cyc(mk(0, 3, 0, 8'h00), "e2_cleared");
    cyc(mk(0, 3, 0, 8'h00), "e2_quiet");

    // Async reset while requesting; held edge source re-requests after release.
    drv(8'h08, 8'hFF, 1, 0, 0); cyc(mk(0, 3, 0, 8'h08), "r_latch");
    cyc(mk(1, 3, 0, 8'h08), "r_req");
    rst_n = 1'b0;
    #2;
    sb.push_back(mk(0, 0, 0, 8'h00));
    cmp("r_async_clear");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(mk(0, 0, 0, 8'h08), "r_reset_rise");
    cyc(mk(1, 3, 0, 8'h08), "r_rereq");
    drv(8'h08, 8'hFF, 1, 1, 0); cyc(mk(0, 3, 1, 8'h08), "r_claim");
    drv(8'h08, 8'hFF, 1, 0, 0); cyc(mk(0, 3, 0, 8'h00), "r_no_rise");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
